sram_req_ctrl: RTL and testbench

Request-side controller for the single-read-port / single-write-port SRAM macro. Converts independent valid/ready read and write request streams from a client into the SRAM's unhandshaked per-cycle address/data/enable pins. Absorbs the macro's fixed one-cycle read latency behind a buffered, backpressurable response channel. Optionally forwards same-cycle write data into read responses.

---
 rtl/sram_req_ctrl_pkg.sv | 25 ++
 rtl/sram_req_ctrl_if.sv | 35 +++
 rtl/sram_req_ctrl_rsp_fifo.sv | 52 +++++
 rtl/sram_req_ctrl.sv | 83 ++++++++
 tb/tb_sram_req_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_req_ctrl_pkg.sv
// Shared defaults and the per-word write-merge helper for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int WIDTH_DEF        = 512;
  localparam int LOG_NUM_ROWS_DEF = 9;
  localparam int WORD_SIZE_DEF    = 64;
  localparam int NUM_WORDS_DEF    = WIDTH_DEF / WORD_SIZE_DEF;
  localparam int RSP_DEPTH        = 3;
  localparam int RSP_CNT_W        = $clog2(RSP_DEPTH + 1);

  // Word i of the result comes from newData when mask[i] is set, otherwise from oldData.
  function automatic logic [WIDTH_DEF-1:0] mergeWords(
    input logic [WIDTH_DEF-1:0]     oldData,
    input logic [WIDTH_DEF-1:0]     newData,
    input logic [NUM_WORDS_DEF-1:0] mask
  );
    logic [WIDTH_DEF-1:0] merged;
    merged = oldData;
    for (int i = 0; i < NUM_WORDS_DEF; i++) begin
      if (mask[i]) merged[i*WORD_SIZE_DEF +: WORD_SIZE_DEF] = newData[i*WORD_SIZE_DEF +: WORD_SIZE_DEF];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Client-side read/write request and read response channels of the SRAM controller.
interface sram_req_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int LOG_NUM_ROWS = LOG_NUM_ROWS_DEF,
  parameter int WORD_SIZE    = WORD_SIZE_DEF
);
  localparam int NUM_WORDS = WIDTH / WORD_SIZE;

  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [LOG_NUM_ROWS-1:0] rd_req_addr;
  logic                    rd_rsp_valid;
  logic                    rd_rsp_ready;
  logic [WIDTH-1:0]        rd_rsp_data;
  logic                    wr_req_valid;
  logic                    wr_req_ready;
  logic [LOG_NUM_ROWS-1:0] wr_req_addr;
  logic [WIDTH-1:0]        wr_req_data;
  logic [NUM_WORDS-1:0]    wr_req_mask;

  modport master (
    output rd_req_valid, rd_req_addr, rd_rsp_ready,
    output wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready
  );

endinterface

// File: rtl/sram_req_ctrl_rsp_fifo.sv
// Small synchronous response FIFO: push and pop may share a cycle, head is read combinationally.
// Pushes into a full FIFO are dropped; the controller's credit check keeps that from happening.
module sram_rsp_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popReady,
  output logic             popValid,
  output logic [WIDTH-1:0] popData,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             push, pop;

  assign push     = pushValid && (count != CNT_W'(DEPTH));
  assign pop      = popReady && (count != '0);
  assign popValid = (count != '0);
  assign popData  = mem[rdPtr];

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for a 1R1W SRAM with 1-cycle read latency; reads return in order, >= 2 cycles.
// Read accept is credit-limited to the 3-entry response buffer; `SRAM_CTRL_FWD_EN forwards same-cycle same-row writes.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int LOG_NUM_ROWS = LOG_NUM_ROWS_DEF,
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  localparam int NUM_WORDS   = WIDTH / WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  sram_req_ctrl_if.slave          client,
  output logic [LOG_NUM_ROWS-1:0] sram_read_addr,
  input  logic [WIDTH-1:0]        sram_read_data,
  output logic [LOG_NUM_ROWS-1:0] sram_write_addr,
  output logic [WIDTH-1:0]        sram_write_data,
  output logic [NUM_WORDS-1:0]    sram_write_enable
);
  logic                 rdFire, wrFire;
  logic                 inflight;
  logic [RSP_CNT_W-1:0] rspCount;
  logic [RSP_CNT_W:0]   occupancy;
  logic [WIDTH-1:0]     rspPushData;

  assign rdFire = client.rd_req_valid && client.rd_req_ready;
  assign wrFire = client.wr_req_valid && client.wr_req_ready;

  assign client.wr_req_ready = !reset;
  assign sram_write_addr     = client.wr_req_addr;
  assign sram_write_data     = client.wr_req_data;
  assign sram_write_enable   = wrFire ? client.wr_req_mask : '0;

  assign sram_read_addr = client.rd_req_addr;

  // Credit check uses registered state only, so rd_rsp_ready never reaches rd_req_ready.
  assign occupancy           = {{RSP_CNT_W{1'b0}}, inflight} + {1'b0, rspCount};
  assign client.rd_req_ready = !reset && (occupancy < (RSP_CNT_W+1)'(RSP_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= rdFire;
  end

`ifdef SRAM_CTRL_FWD_EN
  logic                 fwdHit;
  logic [WIDTH-1:0]     fwdData;
  logic [NUM_WORDS-1:0] fwdMask;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwdHit  <= 1'b0;
      fwdData <= '0;
      fwdMask <= '0;
    end else begin
      fwdHit  <= rdFire && wrFire && (client.rd_req_addr == client.wr_req_addr);
      fwdData <= client.wr_req_data;
      fwdMask <= client.wr_req_mask;
    end
  end

  // The macro returns pre-write data on a same-row collision; patch in the written words.
  assign rspPushData = fwdHit ? mergeWords(sram_read_data, fwdData, fwdMask) : sram_read_data;
`else
  assign rspPushData = sram_read_data;
`endif

  sram_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH),
    .CNT_W (RSP_CNT_W)
  ) u_rspFifo (
    .clk       (clk),
    .reset     (reset),
    .pushValid (inflight),
    .pushData  (rspPushData),
    .popReady  (client.rd_rsp_ready),
    .popValid  (client.rd_rsp_valid),
    .popData   (client.rd_rsp_data),
    .count     (rspCount)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural 1R1W SRAM (all-ones reset fill, read-before-write).
module tb_sram_req_ctrl;
  localparam int WIDTH     = 512;
  localparam int LOGR      = 9;
  localparam int WS        = 64;
  localparam int NW        = WIDTH / WS;
  localparam int NUM_ROWS  = 1 << LOGR;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [LOGR-1:0]  sramRdAddr, sramWrAddr;
  logic [WIDTH-1:0] sramRdData, sramWrData;
  logic [NW-1:0]    sramWe;
  logic [WIDTH-1:0] mem [NUM_ROWS];

  int tests = 0;
  int fails = 0;

  sram_req_ctrl_if bus ();

  sram_req_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .client            (bus),
    .sram_read_addr    (sramRdAddr),
    .sram_read_data    (sramRdData),
    .sram_write_addr   (sramWrAddr),
    .sram_write_data   (sramWrData),
    .sram_write_enable (sramWe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ROWS; r++) mem[r] <= '1;
      sramRdData <= '1;
    end else begin
      sramRdData <= mem[sramRdAddr];
      for (int w = 0; w < NW; w++)
        if (sramWe[w]) mem[sramWrAddr][w*WS +: WS] <= sramWrData[w*WS +: WS];
    end
  end

  function automatic logic [WIDTH-1:0] pat(input int r);
    logic [WIDTH-1:0] v;
    for (int w = 0; w < NW; w++) v[w*WS +: WS] = {16'hC0DE, 16'(r), 32'(w)};
    return v;
  endfunction

  task automatic idle();
    bus.rd_req_valid = 1'b0;
    bus.wr_req_valid = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic writeRow(input int a, input logic [WIDTH-1:0] d, input logic [NW-1:0] m);
    bus.wr_req_valid = 1'b1;
    bus.wr_req_addr  = LOGR'(a);
    bus.wr_req_data  = d;
    bus.wr_req_mask  = m;
    step();
    bus.wr_req_valid = 1'b0;
  endtask

  // Offers one read (plus whatever write is already driven) and waits for its response; lat=0 on timeout.
  task automatic readRow(input int a, output logic [WIDTH-1:0] d, output int lat);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = LOGR'(a);
    bus.rd_rsp_ready = 1'b1;
    step();
    idle();
    lat = 0;
    d   = '0;
    for (int c = 1; c <= 16; c++) begin
      if (lat == 0 && bus.rd_rsp_valid) begin
        d   = bus.rd_rsp_data;
        lat = c;
      end
      if (lat == 0) step();
    end
    step();
  endtask

  task automatic test_reset();
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = '0;
    bus.rd_rsp_ready = 1'b1;
    bus.wr_req_valid = 1'b1;
    bus.wr_req_addr  = '0;
    bus.wr_req_data  = '0;
    bus.wr_req_mask  = '1;
    repeat (3) step();
    tests++; if (bus.rd_req_ready !== 1'b0) begin fails++; $display("FAIL reset_rd_ready: got %b expected 0", bus.rd_req_ready); end
    tests++; if (bus.wr_req_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready: got %b expected 0", bus.wr_req_ready); end
    tests++; if (bus.rd_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rd_rsp_valid); end
    tests++; if (sramWe !== 8'h00) begin fails++; $display("FAIL reset_we: got %h expected 00", sramWe); end
    idle();
    step();
    reset = 1'b0;
    #1;
    tests++; if (bus.rd_req_ready !== 1'b1 || bus.wr_req_ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_ready: got rd=%b wr=%b expected 1 1", bus.rd_req_ready, bus.wr_req_ready);
    end
  endtask

  task automatic test_reset_fill();
    logic [WIDTH-1:0] d;
    int lat;
    readRow(5, d, lat);
    tests++; if (lat != 2) begin fails++; $display("FAIL fill_latency: got %0d expected 2", lat); end
    tests++; if (d !== {WIDTH{1'b1}}) begin fails++; $display("FAIL fill_data: got %h expected all ones", d); end
  endtask

  task automatic test_write_then_read();
    logic [WIDTH-1:0] d, wd;
    int lat;
    wd = '0;
    for (int w = 0; w < NW; w++) wd[w*WS +: WS] = 64'h0123_4567_89AB_CD00 + 64'(w);
    bus.wr_req_valid = 1'b1;
    bus.wr_req_addr  = 9'd7;
    bus.wr_req_data  = wd;
    bus.wr_req_mask  = 8'hFF;
    #1;
    tests++; if (sramWe !== 8'hFF || sramWrAddr !== 9'd7 || sramWrData !== wd) begin
      fails++; $display("FAIL wr_passthru: got we=%h addr=%0d expected we=ff addr=7", sramWe, sramWrAddr);
    end
    step();
    bus.wr_req_valid = 1'b0;
    readRow(7, d, lat);
    tests++; if (lat != 2) begin fails++; $display("FAIL wr_rd_latency: got %0d expected 2", lat); end
    tests++; if (d !== wd) begin fails++; $display("FAIL wr_rd_data: got %h expected %h", d, wd); end
  endtask

  task automatic test_partial_mask();
    logic [WIDTH-1:0] d, wd, exp;
    int lat;
    wd = '0;
    for (int w = 0; w < NW; w++) wd[w*WS +: WS] = 64'hA5A5_0000_0000_0000 + 64'(w);
    exp = '1;
    exp[63:0] = wd[63:0];
    writeRow(3, wd, 8'h01);
    readRow(3, d, lat);
    tests++; if (d !== exp) begin fails++; $display("FAIL mask01_data: got %h expected %h", d, exp); end
    writeRow(4, wd, 8'h00);
    readRow(4, d, lat);
    tests++; if (d !== {WIDTH{1'b1}}) begin fails++; $display("FAIL mask00_data: got %h expected all ones", d); end
  endtask

  task automatic test_same_cycle();
    logic [WIDTH-1:0] d, oldD, newD, exp, post;
    int lat;
    oldD = pat(900);
    newD = pat(901);
    writeRow(9, oldD, 8'hFF);
    post = oldD;
    post[WIDTH-1:256] = newD[WIDTH-1:256];
`ifdef SRAM_CTRL_FWD_EN
    exp = post;
`else
    exp = oldD;
`endif
    bus.wr_req_valid = 1'b1;
    bus.wr_req_addr  = 9'd9;
    bus.wr_req_data  = newD;
    bus.wr_req_mask  = 8'hF0;
    readRow(9, d, lat);
    tests++; if (d !== exp) begin fails++; $display("FAIL same_cycle_data: got %h expected %h", d, exp); end
    readRow(9, d, lat);
    tests++; if (d !== post) begin fails++; $display("FAIL post_write_data: got %h expected %h", d, post); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] got [6];
    int next, n;
    for (int r = 0; r < 6; r++) writeRow(r, pat(r), 8'hFF);
    bus.rd_rsp_ready = 1'b0;
    next = 0;
    for (int c = 0; c < 8; c++) begin
      bus.rd_req_valid = (next < 6);
      bus.rd_req_addr  = LOGR'(next);
      #1;
      if (bus.rd_req_ready && next < 6) next++;
      step();
    end
    tests++; if (next != 3) begin fails++; $display("FAIL bp_accepted: got %0d expected 3", next); end
    tests++; if (bus.rd_req_ready !== 1'b0) begin fails++; $display("FAIL bp_rd_ready: got %b expected 0", bus.rd_req_ready); end
    bus.rd_rsp_ready = 1'b1;
    #1;
    tests++; if (bus.rd_req_ready !== 1'b0) begin fails++; $display("FAIL bp_release_ready: got %b expected 0", bus.rd_req_ready); end
    n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      bus.rd_req_valid = (next < 6);
      bus.rd_req_addr  = LOGR'(next);
      #1;
      if (bus.rd_rsp_valid) begin got[n] = bus.rd_rsp_data; n++; end
      if (bus.rd_req_ready && next < 6) next++;
      step();
    end
    idle();
    tests++; if (n != 6) begin fails++; $display("FAIL bp_rsp_count: got %0d expected 6", n); end
    for (int i = 0; i < n; i++) begin
      tests++; if (got[i] !== pat(i)) begin fails++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], pat(i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    int acc, n, first, last, bad, lat;
    acc = 0; n = 0; first = -1; last = -1; bad = 0;
    bus.rd_rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.rd_req_valid = (c < 6);
      bus.rd_req_addr  = LOGR'(c);
      bus.wr_req_valid = (c < 6);
      bus.wr_req_addr  = LOGR'(20 + c);
      bus.wr_req_data  = pat(20 + c);
      bus.wr_req_mask  = 8'hFF;
      #1;
      if (c < 6 && bus.rd_req_ready && bus.wr_req_ready) acc++;
      if (bus.rd_rsp_valid) begin
        if (n < 6 && bus.rd_rsp_data !== pat(n)) bad++;
        if (first < 0) first = c;
        last = c;
        n++;
      end
      step();
    end
    idle();
    tests++; if (acc != 6) begin fails++; $display("FAIL b2b_accepted: got %0d expected 6", acc); end
    tests++; if (n != 6 || first != 2 || last != 7) begin
      fails++; $display("FAIL b2b_timing: got n=%0d first=%0d last=%0d expected 6 2 7", n, first, last);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_data: got %0d bad responses expected 0", bad); end
    readRow(22, d, lat);
    tests++; if (d !== pat(22)) begin fails++; $display("FAIL b2b_write_data: got %h expected %h", d, pat(22)); end
  endtask

  task automatic test_reset_midflight();
    int stray;
    bus.rd_rsp_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = LOGR'(r);
      step();
    end
    idle();
    tests++; if (bus.rd_req_ready !== 1'b0 || bus.rd_rsp_valid !== 1'b1) begin
      fails++; $display("FAIL mid_state: got ready=%b valid=%b expected 0 1", bus.rd_req_ready, bus.rd_rsp_valid);
    end
    reset = 1'b1;
    step();
    tests++; if (bus.rd_rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b expected 0", bus.rd_rsp_valid); end
    reset = 1'b0;
    bus.rd_rsp_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.rd_rsp_valid) stray++;
      step();
    end
    tests++; if (stray != 0) begin fails++; $display("FAIL mid_stray_rsp: got %0d expected 0", stray); end
    tests++; if (bus.rd_req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_after: got %b expected 1", bus.rd_req_ready); end
  endtask

  initial begin
    test_reset();
    test_reset_fill();
    test_write_then_read();
    test_partial_mask();
    test_same_cycle();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
